// File: rtl/sdram_arbiter.sv
// Two-client front end for sdram_controller: a prioritised read client and a write client
// share one command port; each access is single-word and held stable until completion.
module sdram_arbiter #(
  parameter int ADDR_WIDTH     = 24,
  parameter int DATA_WIDTH     = 16,
  parameter int MAX_READ_RUN   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ack,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  output logic [1:0]            ctrl_command,
  output logic [ADDR_WIDTH-1:0] ctrl_address,
  output logic [DATA_WIDTH-1:0] ctrl_data_write,
  input  logic [DATA_WIDTH-1:0] ctrl_data_read,
  input  logic                  ctrl_data_read_valid,
  input  logic                  ctrl_data_write_done,
  output logic                  timeout_error
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LIMIT   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    RUN_LIMIT = 4'(MAX_READ_RUN);
  localparam logic [1:0]    CMD_IDLE  = 2'd0;
  localparam logic [1:0]    CMD_WR    = 2'd1;
  localparam logic [1:0]    CMD_RD    = 2'd2;

  typedef enum logic [1:0] {IDLE, BUSY_RD, BUSY_WR, GAP} state_t;

  state_t                state_q, state_d;
  logic [3:0]            run_q, run_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic [1:0]            cmd_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d, rd_data_d;
  logic                  rd_ack_d, wr_ack_d, terr_d;

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    tcnt_d    = tcnt_q;
    cmd_d     = ctrl_command;
    addr_d    = ctrl_address;
    wdata_d   = ctrl_data_write;
    rd_data_d = rd_data;
    rd_ack_d  = 1'b0;
    wr_ack_d  = 1'b0;
    terr_d    = timeout_error;
    case (state_q)
      IDLE: begin
        // The run limit only bites while the writer is actually waiting.
        if (rd_req && (!wr_req || run_q < RUN_LIMIT)) begin
          addr_d  = rd_addr;
          cmd_d   = CMD_RD;
          tcnt_d  = '0;
          state_d = BUSY_RD;
          if (!wr_req)              run_d = 4'd0;
          else if (run_q != 4'hF)   run_d = run_q + 4'd1;
        end else if (wr_req) begin
          addr_d  = wr_addr;
          wdata_d = wr_data;
          cmd_d   = CMD_WR;
          tcnt_d  = '0;
          run_d   = 4'd0;
          state_d = BUSY_WR;
        end
      end
      BUSY_RD: begin
        if (ctrl_data_read_valid) begin
          rd_data_d = ctrl_data_read;
          rd_ack_d  = 1'b1;
          cmd_d     = CMD_IDLE;
          state_d   = GAP;
        end else if (tcnt_q == T_LIMIT) begin
          cmd_d   = CMD_IDLE;
          terr_d  = 1'b1;
          state_d = GAP;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      BUSY_WR: begin
        if (ctrl_data_write_done) begin
          wr_ack_d = 1'b1;
          cmd_d    = CMD_IDLE;
          state_d  = GAP;
        end else if (tcnt_q == T_LIMIT) begin
          cmd_d   = CMD_IDLE;
          terr_d  = 1'b1;
          state_d = GAP;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: begin
        // GAP: the ack from the previous cycle drops here; requests are not sampled.
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      run_q           <= 4'd0;
      tcnt_q          <= '0;
      ctrl_command    <= CMD_IDLE;
      ctrl_address    <= '0;
      ctrl_data_write <= '0;
      rd_data         <= '0;
      rd_ack          <= 1'b0;
      wr_ack          <= 1'b0;
      timeout_error   <= 1'b0;
    end else begin
      state_q         <= state_d;
      run_q           <= run_d;
      tcnt_q          <= tcnt_d;
      ctrl_command    <= cmd_d;
      ctrl_address    <= addr_d;
      ctrl_data_write <= wdata_d;
      rd_data         <= rd_data_d;
      rd_ack          <= rd_ack_d;
      wr_ack          <= wr_ack_d;
      timeout_error   <= terr_d;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: controller model, two queue-fed clients and a scoreboard
// matching every ack against results queued when the request was issued.
module tb_sdram_arbiter;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int W  = AW + DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_req = 1'b0, wr_req = 1'b0;
  logic [AW-1:0] rd_addr = '0, wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_ack, wr_ack, timeout_error;
  logic [DW-1:0] rd_data, ctrl_data_write;
  logic [1:0]    ctrl_command;
  logic [AW-1:0] ctrl_address;
  logic [DW-1:0] ctrl_data_read = '0;
  logic          ctrl_data_read_valid = 1'b0, ctrl_data_write_done = 1'b0;

  sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_READ_RUN(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .ctrl_command(ctrl_command), .ctrl_address(ctrl_address),
    .ctrl_data_write(ctrl_data_write), .ctrl_data_read(ctrl_data_read),
    .ctrl_data_read_valid(ctrl_data_read_valid), .ctrl_data_write_done(ctrl_data_write_done),
    .timeout_error(timeout_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
    return (a == 24'h000123) ? 16'hBEEF : (a[15:0] ^ 16'h5A5A);
  endfunction

  logic [AW-1:0] rd_q[$];
  logic [W-1:0]  wr_q[$];
  logic [W-1:0]  exp_rd_q[$];
  logic [W-1:0]  exp_wr_q[$];
  bit            ack_log[$];

  // Controller model: strobes completion after a latency of busy cycles.
  logic hang      = 1'b0;
  int   fixed_lat = 0;
  int   model_rd_cnt = 0, model_wr_cnt = 0;
  initial begin : ctrl_model
    int m_cnt, m_lat;
    m_cnt = 0; m_lat = 1;
    forever begin
      @(negedge clk);
      ctrl_data_read_valid = 1'b0;
      ctrl_data_write_done = 1'b0;
      if (ctrl_command == 2'd0 || rst) begin
        m_cnt = 0;
      end else begin
        if (m_cnt == 0) m_lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
        m_cnt++;
        if (!hang && m_cnt == m_lat) begin
          if (ctrl_command == 2'd2) begin
            ctrl_data_read       = rd_val(ctrl_address);
            ctrl_data_read_valid = 1'b1;
            model_rd_cnt++;
          end else if (ctrl_command == 2'd1) begin
            ctrl_data_write_done = 1'b1;
            model_wr_cnt++;
          end
        end
      end
    end
  end

  // Clients: raise the next request when idle, replace or drop it during the ack cycle.
  initial begin : rd_client
    forever begin
      @(negedge clk);
      if ((!rd_req || rd_ack) && rd_q.size() > 0) begin
        rd_addr = rd_q.pop_front();
        rd_req  = 1'b1;
      end else if (rd_ack) begin
        rd_req = 1'b0;
      end
    end
  end

  initial begin : wr_client
    logic [W-1:0] t;
    forever begin
      @(negedge clk);
      if ((!wr_req || wr_ack) && wr_q.size() > 0) begin
        t = wr_q.pop_front();
        wr_addr = t[W-1:DW];
        wr_data = t[DW-1:0];
        wr_req  = 1'b1;
      end else if (wr_ack) begin
        wr_req = 1'b0;
      end
    end
  end

  // Monitor and scoreboard.
  logic [AW-1:0] cur_addr = '0;
  logic [DW-1:0] cur_wdata = '0;
  logic [41:0]   last_grant = '0;
  int            busy_len = 0, last_busy_len = 0;
  initial begin : monitor
    logic [41:0] prev_vec;
    logic [1:0]  prev_cmd;
    logic        prev_rd_ack, prev_wr_ack;
    prev_vec = '0; prev_cmd = 2'd0; prev_rd_ack = 1'b0; prev_wr_ack = 1'b0;
    forever begin
      @(negedge clk);
      check_eq("cmd_not_3", 64'(ctrl_command == 2'd3), 64'd0);
      if (ctrl_command != 2'd0 && prev_cmd == 2'd0) begin
        cur_addr   = ctrl_address;
        cur_wdata  = ctrl_data_write;
        last_grant = {ctrl_command, ctrl_address, ctrl_data_write};
        busy_len   = 0;
      end
      if (ctrl_command != 2'd0 && prev_cmd != 2'd0)
        check_eq("cmd_hold", 64'({ctrl_command, ctrl_address, ctrl_data_write}), 64'(prev_vec));
      if (ctrl_command != 2'd0) busy_len++;
      else if (prev_cmd != 2'd0) last_busy_len = busy_len;
      if (rd_ack) begin
        check_eq("rd_ack_pulse", 64'(prev_rd_ack), 64'd0);
        check_eq("rd_cmd_dropped", 64'(ctrl_command), 64'd0);
        if (exp_rd_q.size() == 0) check_eq("unexpected_rd_ack", 64'd1, 64'd0);
        else check_eq("rd_result", 64'({cur_addr, rd_data}), 64'(exp_rd_q.pop_front()));
        ack_log.push_back(1'b0);
      end
      if (wr_ack) begin
        check_eq("wr_ack_pulse", 64'(prev_wr_ack), 64'd0);
        check_eq("wr_cmd_dropped", 64'(ctrl_command), 64'd0);
        if (exp_wr_q.size() == 0) check_eq("unexpected_wr_ack", 64'd1, 64'd0);
        else check_eq("wr_result", 64'({cur_addr, cur_wdata}), 64'(exp_wr_q.pop_front()));
        ack_log.push_back(1'b1);
      end
      prev_vec    = {ctrl_command, ctrl_address, ctrl_data_write};
      prev_cmd    = ctrl_command;
      prev_rd_ack = rd_ack;
      prev_wr_ack = wr_ack;
    end
  end

  task automatic push_read(input logic [AW-1:0] a);
    rd_q.push_back(a);
    exp_rd_q.push_back({a, rd_val(a)});
  endtask

  task automatic push_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_q.push_back({a, d});
    exp_wr_q.push_back({a, d});
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      done = (exp_rd_q.size() == 0 && exp_wr_q.size() == 0 && rd_q.size() == 0 &&
              wr_q.size() == 0 && !rd_req && !wr_req);
    end
    if (!done) check_eq({tag, "_idle_timeout"}, 64'd0, 64'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_cmd(input logic [1:0] c, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = (ctrl_command == c);
    end
    if (!seen) check_eq({tag, "_cmd_wait"}, 64'd0, 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cmd"},   64'(ctrl_command), 64'd0);
    check_eq({tag, "_addr"},  64'(ctrl_address), 64'd0);
    check_eq({tag, "_wdata"}, 64'(ctrl_data_write), 64'd0);
    check_eq({tag, "_acks"},  64'({rd_ack, wr_ack}), 64'd0);
    check_eq({tag, "_rdata"}, 64'(rd_data), 64'd0);
    check_eq({tag, "_terr"},  64'(timeout_error), 64'd0);
  endtask

  initial begin : main
    int base, busy;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Single read, CAS 2.
    fixed_lat = 2;
    @(posedge clk); #1;
    push_read(24'h000123);
    wait_idle("single_rd");
    check_eq("rd_grant", 64'(last_grant[41:16]), 64'({2'd2, 24'h000123}));
    check_eq("rd_busy_len", 64'(last_busy_len), 64'd2);
    check_eq("rd_data_hold", 64'(rd_data), 64'hBEEF);
    fixed_lat = 0;

    // Single write.
    base = model_wr_cnt;
    @(posedge clk); #1;
    push_write(24'h0A0010, 16'h1234);
    wait_idle("single_wr");
    check_eq("wr_grant", 64'(last_grant), 64'({2'd1, 24'h0A0010, 16'h1234}));
    check_eq("wr_model_count", 64'(model_wr_cnt - base), 64'd1);

    // Contention: both clients saturating for 20 accesses.
    ack_log.delete();
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) push_read(24'h000100 + 24'(i));
    for (int i = 0; i < 4; i++) push_write(24'h000200 + 24'(i), 16'($urandom_range(0, 65535)));
    wait_idle("contention");
    check_eq("contention_count", 64'(ack_log.size()), 64'd20);
    for (int k = 0; k < 20 && k < ack_log.size(); k++)
      check_eq($sformatf("grant_order_%0d", k), 64'(ack_log[k]), 64'((k % 5) == 4));

    // Back-to-back reads, addresses 0..7.
    base = model_rd_cnt;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) push_read(24'(i));
    wait_idle("b2b_rd");
    check_eq("b2b_model_reads", 64'(model_rd_cnt - base), 64'd8);

    // Timeout on a write, then retry succeeds.
    base = model_wr_cnt;
    hang = 1'b1;
    @(posedge clk); #1;
    push_write(24'h0A0020, 16'hC0DE);
    wait_cmd(2'd1, "timeout");
    busy = 1;
    for (int i = 0; i < 100 && ctrl_command == 2'd1; i++) begin
      @(negedge clk);
      if (ctrl_command == 2'd1) busy++;
    end
    check_eq("timeout_busy_len", 64'(busy), 64'd16);
    check_eq("timeout_err_set", 64'(timeout_error), 64'd1);
    check_eq("timeout_no_ack", 64'(wr_ack), 64'd0);
    hang = 1'b0;
    wait_idle("timeout_retry");
    check_eq("timeout_err_sticky", 64'(timeout_error), 64'd1);
    check_eq("timeout_model_wr", 64'(model_wr_cnt - base), 64'd1);

    // Reset during BUSY_RD; the held request then completes normally.
    hang = 1'b1;
    @(posedge clk); #1;
    push_read(24'h000777);
    wait_cmd(2'd2, "rst_busy");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_busy");
    hang = 1'b0;
    rst  = 1'b0;
    wait_idle("rst_recover");
    check_eq("rst_recover_rdata", 64'(rd_data), 64'(rd_val(24'h000777)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Two-client front end for sdram_controller: a read client (LCD scanline prefetch) and a write client (Julia pixel renderer) share the controller's single command port.
- Serialises single-word accesses and holds command, address and write data stable for the whole access. Drops the command once the controller completes, so the controller never repeats the operation.
- Read has priority. A run limit guarantees the writer forward progress.

Parameters:
- ADDR_WIDTH, 24, user word address width; equals controller bank+row+column width.
- DATA_WIDTH, 16, data word width.
- MAX_READ_RUN, 4, max consecutive read grants while wr_req is pending; range 1..15.
- TIMEOUT_CYCLES, 1024, busy-state cycles without completion before abort.

Ports:
- clk  in  1  system clock, shared with sdram_controller.
- rst  in  1  synchronous, active-high reset.
- rd_req  in  1  read request; held with rd_addr stable until rd_ack.
- rd_addr  in  ADDR_WIDTH  read word address.
- rd_ack  out  1  one-cycle pulse: read complete, rd_data valid.
- rd_data  out  DATA_WIDTH  read word; holds last value until the next read.
- wr_req  in  1  write request; held with wr_addr/wr_data stable until wr_ack.
- wr_addr  in  ADDR_WIDTH  write word address.
- wr_data  in  DATA_WIDTH  write word.
- wr_ack  out  1  one-cycle pulse: write accepted by the SDRAM.
- ctrl_command  out  2  to controller: 0 idle, 1 write, 2 read; 3 is never driven.
- ctrl_address  out  ADDR_WIDTH  to controller data_address.
- ctrl_data_write  out  DATA_WIDTH  to controller data_write.
- ctrl_data_read  in  DATA_WIDTH  from controller data_read.
- ctrl_data_read_valid  in  1  from controller.
- ctrl_data_write_done  in  1  from controller.
- timeout_error  out  1  sticky; set on any aborted access, cleared only by rst.

Behaviour:
- Clocking and reset: single clock clk. rst is synchronous and active-high.
- Reset values:
  - state=IDLE.
  - ctrl_command=0, ctrl_address=0, ctrl_data_write=0.
  - rd_ack=0, wr_ack=0, rd_data=0, timeout_error=0.
  - run_count=0, timeout counter=0.
- rst mid-access: ctrl_command is 0 from the next cycle. No ack is issued for the abandoned access.
- All outputs are registered.
- State machine (IDLE, BUSY_RD, BUSY_WR, GAP):
  - IDLE, read grant: if rd_req && (!wr_req || run_count < MAX_READ_RUN), then latch rd_addr into ctrl_address, ctrl_command<=2, go to BUSY_RD.
  - IDLE, write grant: else if wr_req, then latch wr_addr/wr_data into ctrl_address/ctrl_data_write, ctrl_command<=1, go to BUSY_WR.
  - IDLE, no request: stay in IDLE with ctrl_command=0.
  - Grant latency: request sampled in IDLE at edge N; ctrl_command is nonzero from edge N.
  - BUSY_RD: hold ctrl_* stable. On ctrl_data_read_valid=1: rd_data<=ctrl_data_read, rd_ack<=1, ctrl_command<=0, go to GAP.
  - BUSY_WR: hold ctrl_* stable. On ctrl_data_write_done=1: wr_ack<=1, ctrl_command<=0, go to GAP.
  - GAP: exactly one cycle with ctrl_command=0 and the ack high. Next edge: ack<=0, go to IDLE. Requests are ignored during GAP.
  - Client handshake: the client may drop or replace its request at the edge ending the ack cycle. The earliest next grant is the edge after that.
- Run counter (4 bits):
  - Read grant while wr_req=1: run_count increments, saturating at 15.
  - Read grant while wr_req=0: run_count clears.
  - Any write grant: run_count clears.
  - Effect: with both clients saturating, the grant pattern is MAX_READ_RUN reads, then 1 write, repeating.
- Timeout:
  - Counter clears on entry to BUSY_* and increments each BUSY cycle.
  - Reaching TIMEOUT_CYCLES-1 without completion: ctrl_command<=0, timeout_error<=1, go to GAP with no ack.
  - The client still holds its request, so it is retried via normal arbitration.
  - A completion in the same cycle as the timeout limit takes precedence: normal ack, no error.
- Completion strobes arriving in IDLE or GAP are ignored.
- Width rules: address and data pass through unmodified. Counter width is $clog2(TIMEOUT_CYCLES).

Test Plan:
- Single read: rd_req, rd_addr=0x000123. Controller model returns 0xBEEF with CAS 2 → ctrl_command=2 with address 0x000123 held until valid; rd_ack 1 cycle; rd_data=0xBEEF; ctrl_command=0 the cycle after valid.
- Single write: wr_req, wr_addr=0x0A0010, wr_data=0x1234 → ctrl_command=1 with data 0x1234 held until write_done; wr_ack 1 cycle; exactly one write seen by the model.
- Contention: rd_req and wr_req held high for 20 accesses, MAX_READ_RUN=4 → grant sequence R,R,R,R,W repeating; no access lost or duplicated.
- Back-to-back reads, addresses 0..7 → exactly 8 model reads in order; every grant is separated by ≥1 cycle with ctrl_command=0.
- Timeout: model never asserts done, TIMEOUT_CYCLES=16 → command drops after 16 busy cycles; timeout_error=1 and stays 1; request is re-granted; model responds on retry → wr_ack.
- Reset during BUSY_RD → ctrl_command=0 next cycle; no rd_ack; all outputs at reset values; a new read after reset completes normally.
